// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared state encoding and beat-index width helper for the cache controller
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITE,
        WRITEBACK,
        REFILL,
        UPDATE,
        WTHRU,
        RESPOND
    } state_t;

    function automatic int beat_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_evt_counter.sv
// cache_evt_counter: saturating event counter with synchronous clear (clear beats increment)
module cache_evt_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    // count up to all-ones and hold there; reset or clear returns to zero
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr)
            o_cnt <= '0;
        else if (i_inc && !(&o_cnt))
            o_cnt <= o_cnt + 1'b1;
    end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: cache access controller; write-back/write-allocate when CACHE_CTRL_WRITE_BACK_EN is defined, write-through/no-allocate otherwise
module cache_ctrl_fsm
    import cache_ctrl_pkg::*;
#(
    parameter  int LINE_WORDS = 4,
    parameter  int CNT_W      = 16,
    localparam int BW         = beat_w(LINE_WORDS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req,
    input  logic             i_wr,
    input  logic             i_hit,
    input  logic             i_dirty,
    input  logic             i_mem_ack,
    input  logic             i_clr_cnt,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_data_we,
    output logic             o_tag_we,
    output logic             o_set_dirty,
    output logic             o_mem_req,
    output logic             o_mem_wr,
    output logic [BW-1:0]    o_beat,
    output logic [CNT_W-1:0] o_hit_cnt,
    output logic [CNT_W-1:0] o_miss_cnt
);

`ifdef CACHE_CTRL_WRITE_BACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    state_t        state, nxt;
    logic [BW-1:0] nbeat;
    logic          wr_q, retry, data_we_q, last, hit_inc, miss_inc;

    assign last      = o_beat == BW'(LINE_WORDS - 1);
    assign hit_inc   = state == LOOKUP && !retry && i_hit;
    assign miss_inc  = state == LOOKUP && !retry && !i_hit;
    assign o_data_we = data_we_q | (state == REFILL && i_mem_ack && !i_rst);

    // next-state and burst-index logic; bursts advance only on an accepted beat
    always_comb begin
        nxt   = state;
        nbeat = o_beat;
        case (state)
            IDLE:      nxt = i_req ? LOOKUP : IDLE;
            LOOKUP:    nxt = i_hit ? (wr_q ? WRITE : RESPOND)
                                   : (WB && i_dirty) ? WRITEBACK : (!WB && wr_q) ? WTHRU : REFILL;
            WRITE:     nxt = WB ? RESPOND : WTHRU;
            WRITEBACK: if (i_mem_ack) begin
                nbeat = last ? '0 : o_beat + 1'b1;
                nxt   = last ? REFILL : WRITEBACK;
            end
            REFILL:    if (i_mem_ack) begin
                nbeat = last ? '0 : o_beat + 1'b1;
                nxt   = last ? UPDATE : REFILL;
            end
            UPDATE:    nxt = LOOKUP;
            WTHRU:     nxt = i_mem_ack ? RESPOND : WTHRU;
            RESPOND:   nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    // state register with Moore outputs registered from the next state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            o_beat      <= '0;
            wr_q        <= 1'b0;
            retry       <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            data_we_q   <= 1'b0;
            o_tag_we    <= 1'b0;
            o_set_dirty <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_wr    <= 1'b0;
        end else begin
            state       <= nxt;
            o_beat      <= nbeat;
            wr_q        <= (state == IDLE && i_req) ? i_wr : wr_q;
            retry       <= (state == UPDATE) ? 1'b1 : (state == IDLE) ? 1'b0 : retry;
            o_busy      <= nxt != IDLE;
            o_done      <= nxt == RESPOND;
            data_we_q   <= nxt == WRITE;
            o_tag_we    <= nxt == UPDATE;
            o_set_dirty <= WB && nxt == WRITE;
            o_mem_req   <= nxt inside {WRITEBACK, REFILL, WTHRU};
            o_mem_wr    <= nxt inside {WRITEBACK, WTHRU};
        end
    end

    cache_evt_counter #(.W(CNT_W)) u_hit_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clr_cnt),
        .i_inc (hit_inc),
        .o_cnt (o_hit_cnt)
    );

    cache_evt_counter #(.W(CNT_W)) u_miss_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clr_cnt),
        .i_inc (miss_inc),
        .o_cnt (o_miss_cnt)
    );

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb_cache_ctrl_fsm: directed self-checking bench for cache_ctrl_fsm (LINE_WORDS=4, CNT_W=2)
module tb_cache_ctrl_fsm;

    logic       i_clk = 1'b0;
    logic       i_rst, i_req, i_wr, i_hit, i_dirty, i_mem_ack, i_clr_cnt;
    logic       o_busy, o_done, o_data_we, o_tag_we, o_set_dirty, o_mem_req, o_mem_wr;
    logic [1:0] o_beat, o_hit_cnt, o_miss_cnt;

    int         n_checks = 0;
    int         n_err = 0;
    int         done_cyc, we_cnt, tag_cyc, wb_n, rd_n, stall_err;
    bit         dirty_seen, mem_seen, refill_seen, found;
    logic [7:0] wb_beats, rd_beats;

    cache_ctrl_fsm #(.LINE_WORDS(4), .CNT_W(2)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_wr        (i_wr),
        .i_hit       (i_hit),
        .i_dirty     (i_dirty),
        .i_mem_ack   (i_mem_ack),
        .i_clr_cnt   (i_clr_cnt),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_data_we   (o_data_we),
        .o_tag_we    (o_tag_we),
        .o_set_dirty (o_set_dirty),
        .o_mem_req   (o_mem_req),
        .o_mem_wr    (o_mem_wr),
        .o_beat      (o_beat),
        .o_hit_cnt   (o_hit_cnt),
        .o_miss_cnt  (o_miss_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_counters();
        i_clr_cnt = 1'b1;
        @(posedge i_clk); #1;
        i_clr_cnt = 1'b0;
    endtask

    // issue one access at edge 0 and log per-cycle activity until o_done (cycle 1 = first cycle after edge 0)
    task automatic run_access(input logic wr, input logic hit, input logic dirty,
                              input logic alt, input logic clr_lookup);
        logic [1:0] hold_beat;
        bit         hold;
        done_cyc = 0; we_cnt = 0; tag_cyc = 0; wb_n = 0; rd_n = 0; stall_err = 0;
        dirty_seen = 0; mem_seen = 0; refill_seen = 0; wb_beats = '0; rd_beats = '0;
        hold = 0; hold_beat = '0;
        i_req = 1'b1; i_wr = wr; i_hit = hit; i_dirty = dirty; i_mem_ack = 1'b0;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            i_mem_ack = alt ? (c % 2 == 0) : 1'b1;
            i_clr_cnt = clr_lookup && c == 1;
            #1;
            if (hold && o_mem_req && o_beat != hold_beat) stall_err++;
            hold      = o_mem_req && !i_mem_ack;
            hold_beat = o_beat;
            if (o_data_we) we_cnt++;
            if (o_mem_req && !o_mem_wr) refill_seen = 1;
            if (o_mem_req && !o_mem_wr && i_mem_ack && rd_n < 4) begin
                rd_beats[rd_n*2 +: 2] = o_beat;
                rd_n++;
            end
            if (o_mem_req && o_mem_wr && i_mem_ack && wb_n < 4) begin
                wb_beats[wb_n*2 +: 2] = o_beat;
                wb_n++;
            end
            mem_seen   |= o_mem_req;
            dirty_seen |= o_set_dirty;
            if (o_tag_we) begin
                tag_cyc = c;
                i_hit   = 1'b1;
            end
            if (o_done) done_cyc = c;
            @(posedge i_clk); #1;
        end
        i_mem_ack = 1'b0;
        i_clr_cnt = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_req = 0; i_wr = 0; i_hit = 0; i_dirty = 0; i_mem_ack = 0; i_clr_cnt = 0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_mem_req", o_mem_req, 0);
        check("rst_data_we", o_data_we, 0);
        check("rst_beat", o_beat, 0);
        check("rst_hit_cnt", o_hit_cnt, 0);
        check("rst_miss_cnt", o_miss_cnt, 0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        run_access(0, 1, 0, 0, 0);
        check("rd_hit_done_cyc", done_cyc, 2);
        check("rd_hit_hit_cnt", o_hit_cnt, 1);
        check("rd_hit_miss_cnt", o_miss_cnt, 0);
        check("rd_hit_mem_req", mem_seen, 0);
        check("rd_hit_idle", o_busy, 0);

        clr_counters();
        run_access(1, 1, 0, 0, 0);
        check("wr_hit_we_cnt", we_cnt, 1);
        check("wr_hit_hit_cnt", o_hit_cnt, 1);
`ifdef CACHE_CTRL_WRITE_BACK_EN
        check("wr_hit_done_cyc", done_cyc, 3);
        check("wr_hit_set_dirty", dirty_seen, 1);
        check("wr_hit_mem_req", mem_seen, 0);
`else
        check("wr_hit_done_cyc", done_cyc, 4);
        check("wr_hit_set_dirty", dirty_seen, 0);
        check("wr_hit_wthru_beats", wb_n, 1);
`endif

        clr_counters();
        run_access(0, 0, 0, 0, 0);
        check("rd_miss_we_cnt", we_cnt, 4);
        check("rd_miss_beats", rd_beats, 8'he4);
        check("rd_miss_tag_cyc", tag_cyc, 6);
        check("rd_miss_done_cyc", done_cyc, 8);
        check("rd_miss_miss_cnt", o_miss_cnt, 1);
        check("rd_miss_hit_cnt", o_hit_cnt, 0);

        clr_counters();
`ifdef CACHE_CTRL_WRITE_BACK_EN
        run_access(0, 0, 1, 1, 0);
        check("dirty_wb_n", wb_n, 4);
        check("dirty_wb_beats", wb_beats, 8'he4);
        check("dirty_rd_n", rd_n, 4);
        check("dirty_rd_beats", rd_beats, 8'he4);
        check("dirty_stall", stall_err, 0);
        check("dirty_done_cyc", done_cyc, 19);
        check("dirty_miss_cnt", o_miss_cnt, 1);
`else
        run_access(1, 0, 1, 0, 0);
        check("wr_miss_done_cyc", done_cyc, 3);
        check("wr_miss_wthru_beats", wb_n, 1);
        check("wr_miss_refill", refill_seen, 0);
        check("wr_miss_set_dirty", dirty_seen, 0);
        check("wr_miss_tag_we", tag_cyc, 0);
        check("wr_miss_we_cnt", we_cnt, 0);
        check("wr_miss_miss_cnt", o_miss_cnt, 1);
`endif

        clr_counters();
        repeat (5) run_access(0, 1, 0, 0, 0);
        check("sat_hit_cnt", o_hit_cnt, 3);
        clr_counters();
        run_access(0, 1, 0, 0, 0);
        check("pre_clr_hit_cnt", o_hit_cnt, 1);
        run_access(0, 1, 0, 0, 1);
        check("clr_wins_hit_cnt", o_hit_cnt, 0);

        found = 0;
        i_req = 1'b1; i_wr = 1'b0; i_hit = 1'b0; i_dirty = 1'b0; i_mem_ack = 1'b1;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (o_mem_req && !o_mem_wr && o_beat == 2) found = 1;
            else begin
                @(posedge i_clk); #1;
            end
        end
        check("rst_mid_reached_beat2", found, 1);
        check("rst_mid_miss_before", o_miss_cnt, 1);
        i_rst = 1'b1;
        #1;
        check("rst_mid_data_we_during", o_data_we, 0);
        @(posedge i_clk); #1;
        check("rst_mid_busy", o_busy, 0);
        check("rst_mid_mem_req", o_mem_req, 0);
        check("rst_mid_beat", o_beat, 0);
        check("rst_mid_miss_cnt", o_miss_cnt, 0);
        check("rst_mid_hit_cnt", o_hit_cnt, 0);
        i_rst = 1'b0;
        i_mem_ack = 1'b0;
        @(posedge i_clk); #1;
        check("post_rst_idle", o_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
